// File: rtl/morse_pkg.sv
// Symbol codes shared between the key sequencer and the alphabet FSM.
package morse_pkg;

    typedef logic [2:0] sym_t;

    localparam sym_t SYM_WAIT  = 3'd0;
    localparam sym_t SYM_DIT   = 3'd1;
    localparam sym_t SYM_DAH   = 3'd2;
    localparam sym_t SYM_GAP   = 3'd3;
    localparam sym_t SYM_SPACE = 3'd4;

    function automatic logic is_symbol(input sym_t code);
        return code != SYM_WAIT;
    endfunction

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Symbol stream from the key sequencer towards the alphabet FSM.
interface morse_symbol_sequencer_if;
    import morse_pkg::*;

    sym_t sym_code;
    logic sym_valid;
    logic err;
    logic busy;

    modport master (output sym_code, output sym_valid, output err, output busy);
    modport slave  (input  sym_code, input  sym_valid, input  err, input  busy);
endinterface

// File: rtl/morse_unit_timer.sv
// Prescaler plus saturating 4-bit count of whole Morse units since the last clear.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    output logic [3:0] units
);
    localparam int PW = $clog2(UNIT_CYCLES);

    logic [PW-1:0] presc_reg;
    logic [3:0]    units_reg;

    // The edge cycle that asserts clr is itself unit-cycle 0, so the
    // prescaler restarts at 1; a mark of N*UNIT_CYCLES cycles then reads N units.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            units_reg <= '0;
        end else if (clr) begin
            presc_reg <= PW'(1);
            units_reg <= '0;
        end else if (presc_reg == PW'(UNIT_CYCLES - 1)) begin
            presc_reg <= '0;
            if (units_reg != 4'hF)
                units_reg <= units_reg + 4'd1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign units = units_reg;

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Classifies a raw key into DIT/DAH/GAP/SPACE symbols with letter-length and stuck-key limits.
module morse_symbol_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int DAH_UNITS   = 2,
    parameter int GAP_UNITS   = 3,
    parameter int SPACE_UNITS = 7,
    parameter int STUCK_UNITS = 15,
    parameter int MAX_SYMS    = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            key,
    morse_symbol_sequencer_if.master        seq
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MARK  = 2'd1;
    localparam logic [1:0] ST_OFF   = 2'd2;
    localparam logic [1:0] ST_STUCK = 2'd3;
    localparam int CW = $clog2(MAX_SYMS + 1);

    logic          key_meta_reg, key_s_reg, key_d_reg;
    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] sym_cnt_reg, sym_cnt_next;
    logic          gap_sent_reg, gap_sent_next;
    sym_t          sym_code_reg, sym_code_next;
    logic          sym_valid_reg, err_reg, err_next, busy_reg;
    logic          key_rise, key_fall;
    logic [3:0]    units;

    assign key_rise = key_s_reg & ~key_d_reg;
    assign key_fall = ~key_s_reg & key_d_reg;

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (key_rise | key_fall),
        .units (units)
    );

    // Edges are handled before thresholds, so an edge coinciding with a
    // threshold restarts timing instead of emitting the threshold symbol.
    always_comb begin
        state_next    = state_reg;
        sym_cnt_next  = sym_cnt_reg;
        gap_sent_next = gap_sent_reg;
        sym_code_next = SYM_WAIT;
        err_next      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (key_rise) begin
                    state_next    = ST_MARK;
                    gap_sent_next = 1'b0;
                end
            end
            ST_MARK: begin
                if (key_fall) begin
                    state_next = ST_OFF;
                    if (sym_cnt_reg == CW'(MAX_SYMS)) begin
                        sym_code_next = SYM_GAP;
                        err_next      = 1'b1;
                        sym_cnt_next  = '0;
                        gap_sent_next = 1'b1;
                    end else begin
                        sym_code_next = (units >= 4'(DAH_UNITS)) ? SYM_DAH : SYM_DIT;
                        sym_cnt_next  = sym_cnt_reg + 1'b1;
                    end
                end else if (units >= 4'(STUCK_UNITS)) begin
                    state_next = ST_STUCK;
                    err_next   = 1'b1;
                end
            end
            ST_OFF: begin
                if (key_rise) begin
                    state_next    = ST_MARK;
                    gap_sent_next = 1'b0;
                end else if (units == 4'(SPACE_UNITS)) begin
                    sym_code_next = SYM_SPACE;
                    state_next    = ST_IDLE;
                end else if (units == 4'(GAP_UNITS) && !gap_sent_reg) begin
                    sym_code_next = SYM_GAP;
                    gap_sent_next = 1'b1;
                    sym_cnt_next  = '0;
                end
            end
            ST_STUCK: begin
                if (key_fall) begin
                    sym_code_next = SYM_GAP;
                    sym_cnt_next  = '0;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_reg  <= 1'b0;
            key_s_reg     <= 1'b0;
            key_d_reg     <= 1'b0;
            state_reg     <= ST_IDLE;
            sym_cnt_reg   <= '0;
            gap_sent_reg  <= 1'b1;
            sym_code_reg  <= SYM_WAIT;
            sym_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            key_meta_reg  <= key;
            key_s_reg     <= key_meta_reg;
            key_d_reg     <= key_s_reg;
            state_reg     <= state_next;
            sym_cnt_reg   <= sym_cnt_next;
            gap_sent_reg  <= gap_sent_next;
            sym_code_reg  <= sym_code_next;
            sym_valid_reg <= is_symbol(sym_code_next);
            err_reg       <= err_next;
            busy_reg      <= (state_next != ST_IDLE);
        end
    end

    assign seq.sym_code  = sym_code_reg;
    assign seq.sym_valid = sym_valid_reg;
    assign seq.err       = err_reg;
    assign seq.busy      = busy_reg;

endmodule

// File: doc/morse_symbol_sequencer.md
# morse_symbol_sequencer

Front-end controller for the Morse alphabet FSM. It samples a raw key level, measures mark and space durations in Morse time units, and issues one symbol code per event to the alphabet FSM's 3-bit input: DIT, DAH, GAP (end of letter), SPACE (end of word), and WAIT otherwise. It also enforces letter-length and stuck-key limits, so the alphabet FSM only ever sees a legal symbol stream.

## Interface
- UNIT_CYCLES, 4: clk cycles per Morse unit; ≥2.
- DAH_UNITS, 2: a mark of ≥ this many whole units is a DAH.
- GAP_UNITS, 3: key-up units that end a letter.
- SPACE_UNITS, 7: key-up units that end a word; > GAP_UNITS.
- STUCK_UNITS, 15: a mark reaching this is a stuck key; ≤15.
- MAX_SYMS, 5: maximum DIT/DAH symbols per letter.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- key  in  1  raw key level, 1 = key down, asynchronous to clk.
- sym_code  out  3  WAIT=0, DIT=1, DAH=2, GAP=3, SPACE=4; feeds the alphabet FSM input.
- sym_valid  out  1  high exactly in cycles where sym_code ≠ WAIT.
- err  out  1  one-cycle pulse on a letter-overflow or stuck-key event.
- busy  out  1  high in every state except IDLE.

## Operation
- key passes through a 2-flop synchronizer to give key_s. Only key_s is used.
- Timer: the prescaler counts 0..UNIT_CYCLES-1. On wrap, units increments, saturating at 15. Both counters clear on every key_s edge.
- States: IDLE, MARK, OFF, STUCK.
- IDLE:
  - key_s rise → MARK.
  - No output.
- MARK:
  - key_s fall with units < DAH_UNITS → emit DIT, go to OFF.
  - key_s fall with units ≥ DAH_UNITS → emit DAH, go to OFF.
  - units reaching STUCK_UNITS → pulse err, go to STUCK.
- Letter overflow: sym_cnt (0..MAX_SYMS) counts symbols in the current letter.
  - If a key_s fall occurs with sym_cnt == MAX_SYMS, emit GAP instead of DIT/DAH.
  - Same cycle: pulse err, clear sym_cnt, go to OFF with the gap_sent flag set.
- OFF:
  - key_s rise → MARK. The letter continues.
  - units reaching GAP_UNITS with gap_sent clear → emit GAP, set gap_sent, clear sym_cnt.
  - units reaching SPACE_UNITS → emit SPACE, go to IDLE.
  - gap_sent clears on entry to MARK.
- STUCK:
  - No symbols are emitted.
  - key_s fall → emit GAP, clear sym_cnt, go to IDLE.
- SPACE is emitted at most once per silence. IDLE never re-emits it.
- A key_s edge and a units threshold in the same cycle: the edge wins. The counters clear and no threshold symbol is emitted.

## Timing
- Reset values: sym_code=WAIT, sym_valid=0, err=0, busy=0, state=IDLE, all counters 0, gap_sent=1.
- Every output is registered.
- Symbols are one-cycle pulses. sym_code returns to WAIT the next cycle.
- Latency from a key pin edge to a classified DIT/DAH on sym_code is 3 clk edges: 2 for sync, 1 for output.
- Durations are quantized by the prescaler.
  - Mark length is measured as whole units completed before key_s fall.
  - GAP is emitted in the cycle units becomes GAP_UNITS, i.e. GAP_UNITS×UNIT_CYCLES cycles after the key_s fall, plus 1 cycle for the output register.
- At most one symbol per cycle. Minimum spacing between symbols is 2 cycles.
- Asserting rst_n low mid-letter drops the partial letter. No GAP is emitted. Outputs return to reset values immediately, asynchronously.

## Structure
- Shared package morse_pkg holds the 3-bit symbol code constants (WAIT, DIT, DAH, GAP, SPACE). The alphabet FSM also uses them.
- The state encoding is local.
- Sub-module morse_unit_timer holds the prescaler plus the saturating 4-bit unit counter.
  - Inputs: clk, rst_n, clr.
  - Output: units.

## Test plan
All scenarios use default parameters (UNIT_CYCLES=4).
- Key down 4 cycles, up 40 cycles → DIT, then GAP 12+1 cycles after release is seen, then SPACE at 28+1 cycles. busy falls after SPACE.
- Key down 8 cycles, up 4, down 12, up 16 → DAH, then DAH, then a single GAP. No SPACE. The sequence sent to the alphabet FSM decodes as M.
- Six 4-cycle marks separated by 4-cycle spaces → five DITs, then GAP instead of the 6th DIT with a coincident err pulse. Only one GAP follows.
- Key held 80 cycles → err at unit 15, no DIT/DAH, GAP one cycle after release is seen, state IDLE.
- Key pulses 1 cycle wide or glitch shorter than 1 clk → a synchronized 1-cycle mark yields DIT. A sub-cycle glitch either yields DIT or nothing; the bench must never see an X.
- rst_n asserted in the middle of a DAH, then released → sym_code=WAIT, no symbol emitted, next key press starts a fresh letter (sym_cnt=0).
